// File: rtl/raster_scan_ctrl_if.sv
// raster_scan_ctrl_if: control, region and pixel stream bundle
// for the raster scan sequencer.
interface raster_scan_ctrl_if #(
  parameter int COORD_BITS = 10
);
  logic                  start;
  logic                  abort;
  logic [COORD_BITS-1:0] x0;
  logic [COORD_BITS-1:0] y0;
  logic [COORD_BITS-1:0] width;
  logic [COORD_BITS-1:0] height;
  logic                  out_ready;
  logic                  out_valid;
  logic [COORD_BITS-1:0] px;
  logic [COORD_BITS-1:0] py;
  logic                  last;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort,
    output x0, y0, width, height,
    output out_ready,
    input  out_valid, px, py, last,
    input  busy, done
  );

  modport slave (
    input  start, abort,
    input  x0, y0, width, height,
    input  out_ready,
    output out_valid, px, py, last,
    output busy, done
  );
endinterface

// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks a rectangular region row by row and
// streams one (x, y) coordinate per accepted beat.
module raster_scan_ctrl #(
  parameter int COORD_BITS = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  raster_scan_ctrl_if.slave  bus
);

  localparam int CB = COORD_BITS;
  localparam logic [CB-1:0] ONE = CB'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [CB-1:0] x0_q;
  logic [CB-1:0] y0_q;
  logic [CB-1:0] w_q;
  logic [CB-1:0] h_q;
  logic [CB-1:0] xc;
  logic [CB-1:0] yc;

  logic          accept;
  logic          row_end;
  logic [CB-1:0] nxc;
  logic [CB-1:0] nyc;
  logic          nlast;

  // Next column/row position once the current beat is taken.
  always_comb begin
    accept  = bus.out_valid & bus.out_ready;
    row_end = (xc == w_q - ONE);
    nxc     = row_end ? '0 : xc + ONE;
    nyc     = row_end ? yc + ONE : yc;
    nlast   = (nxc == w_q - ONE) && (nyc == h_q - ONE);
  end

  // Sequencer FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      xc            <= '0;
      yc            <= '0;
      bus.out_valid <= 1'b0;
      bus.px        <= '0;
      bus.py        <= '0;
      bus.last      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.width != '0 && bus.height != '0) begin
              state         <= SCAN;
              x0_q          <= bus.x0;
              y0_q          <= bus.y0;
              w_q           <= bus.width;
              h_q           <= bus.height;
              xc            <= '0;
              yc            <= '0;
              bus.out_valid <= 1'b1;
              bus.px        <= bus.x0;
              bus.py        <= bus.y0;
              bus.last      <= (bus.width == ONE) &&
                               (bus.height == ONE);
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.abort) begin
            state         <= IDLE;
            xc            <= '0;
            yc            <= '0;
            bus.out_valid <= 1'b0;
            bus.px        <= '0;
            bus.py        <= '0;
            bus.last      <= 1'b0;
            bus.busy      <= 1'b0;
          end else if (accept) begin
            if (bus.last) begin
              state         <= DONE;
              xc            <= '0;
              yc            <= '0;
              bus.out_valid <= 1'b0;
              bus.px        <= '0;
              bus.py        <= '0;
              bus.last      <= 1'b0;
              bus.done      <= 1'b1;
            end else begin
              xc       <= nxc;
              yc       <= nyc;
              bus.px   <= x0_q + nxc;
              bus.py   <= y0_q + nyc;
              bus.last <= nlast;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb_raster_scan_ctrl: directed and randomized scans checked
// against a list-of-beats model built from the region geometry.
module tb_raster_scan_ctrl;

  localparam int CB = 10;
  localparam int M  = 1 << CB;

  logic clk;
  logic n_rst;
  int   n_chk;
  int   n_pass;

  raster_scan_ctrl_if #(.COORD_BITS(CB)) bus ();

  raster_scan_ctrl #(.COORD_BITS(CB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    bit l;
  } beat_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(bus.out_valid), 0);
    chk({tag, " busy"},  32'(bus.busy), 0);
    chk({tag, " done"},  32'(bus.done), 0);
  endtask

  // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random
  task automatic run_scan(input int ax0, input int ay0,
                          input int aw, input int ah,
                          input int mode, input int abort_after,
                          input bit noise, input string tag);
    beat_t q[$];
    beat_t b;
    int    acc;
    int    cyc;
    bit    rdy;
    for (int yy = 0; yy < ah; yy++) begin
      for (int xx = 0; xx < aw; xx++) begin
        b.x = (ax0 + xx) % M;
        b.y = (ay0 + yy) % M;
        b.l = (xx == aw - 1) && (yy == ah - 1);
        q.push_back(b);
      end
    end
    bus.x0     = CB'(ax0);
    bus.y0     = CB'(ay0);
    bus.width  = CB'(aw);
    bus.height = CB'(ah);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    if (aw == 0 || ah == 0) begin
      chk({tag, " zero valid"}, 32'(bus.out_valid), 0);
      chk({tag, " zero done"},  32'(bus.done), 1);
      chk({tag, " zero busy"},  32'(bus.busy), 1);
      step();
      chk_idle({tag, " zero after"});
      return;
    end
    acc = 0;
    cyc = 0;
    while (q.size() > 0) begin
      if (cyc > aw * ah * 8 + 20) begin
        chk({tag, " timeout left"}, 32'(q.size()), 0);
        bus.out_ready = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      if (noise) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.x0     = CB'($urandom);
        bus.y0     = CB'($urandom);
        bus.width  = CB'($urandom);
        bus.height = CB'($urandom);
      end
      chk({tag, " valid"}, 32'(bus.out_valid), 1);
      chk({tag, " px"},    32'(bus.px), 32'(q[0].x));
      chk({tag, " py"},    32'(bus.py), 32'(q[0].y));
      chk({tag, " last"},  32'(bus.last), 32'(q[0].l));
      chk({tag, " busy"},  32'(bus.busy), 1);
      chk({tag, " done"},  32'(bus.done), 0);
      if (abort_after >= 0 && acc == abort_after) begin
        bus.abort     = 1'b1;
        bus.out_ready = rdy;
        step();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk_idle({tag, " abort"});
        step();
        chk_idle({tag, " abort+1"});
        return;
      end
      bus.out_ready = rdy;
      step();
      bus.start = 1'b0;
      cyc++;
      if (rdy) begin
        void'(q.pop_front());
        acc++;
      end
    end
    bus.out_ready = 1'b0;
    chk({tag, " beats"},      32'(acc), 32'(aw * ah));
    chk({tag, " end valid"},  32'(bus.out_valid), 0);
    chk({tag, " end done"},   32'(bus.done), 1);
    chk({tag, " end busy"},   32'(bus.busy), 1);
    chk({tag, " end last"},   32'(bus.last), 0);
    step();
    chk_idle({tag, " after"});
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.x0        = '0;
    bus.y0        = '0;
    bus.width     = '0;
    bus.height    = '0;
    bus.out_ready = 1'b0;
    n_rst         = 1'b0;
    repeat (2) step();
    chk_idle("reset");
    chk("reset px",   32'(bus.px), 0);
    chk("reset py",   32'(bus.py), 0);
    chk("reset last", 32'(bus.last), 0);
    n_rst = 1'b1;
    step();

    run_scan(5, 7, 3, 2, 0, -1, 1'b0, "basic");
    run_scan(5, 7, 3, 2, 1, -1, 1'b0, "bp");
    run_scan(0, 0, 0, 4, 0, -1, 1'b0, "zero_w");
    run_scan(3, 3, 5, 0, 0, -1, 1'b0, "zero_h");
    run_scan(2, 4, 4, 4, 0, 5, 1'b0, "abort");
    run_scan(2, 4, 4, 4, 0, -1, 1'b0, "post_abort");
    run_scan(9, 9, 1, 1, 0, 0, 1'b0, "abort_last");
    run_scan(9, 9, 1, 1, 0, -1, 1'b0, "single");
    run_scan(1022, 0, 4, 1, 0, -1, 1'b0, "wrap_x");
    run_scan(3, 1021, 2, 5, 1, -1, 1'b0, "wrap_y");
    run_scan(10, 20, 3, 3, 2, -1, 1'b1, "start_mid");

    bus.x0        = '0;
    bus.y0        = '0;
    bus.width     = CB'(3);
    bus.height    = CB'(3);
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rst beat3 px", 32'(bus.px), 2);
    chk("rst beat3 py", 32'(bus.py), 0);
    #2;
    n_rst = 1'b0;
    #1;
    chk_idle("async rst");
    chk("async rst px",   32'(bus.px), 0);
    chk("async rst py",   32'(bus.py), 0);
    chk("async rst last", 32'(bus.last), 0);
    bus.out_ready = 1'b0;
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("post rst");
    end

    for (int i = 0; i < 10; i++) begin
      run_scan($urandom_range(0, M - 1),
               $urandom_range(0, M - 1),
               $urandom_range(1, 6),
               $urandom_range(1, 5),
               2, -1, 1'b1, "random");
    end
    run_scan(7, 7, 5, 3, 2, 6, 1'b1, "rand_abort");
    run_scan(7, 7, 5, 3, 2, -1, 1'b0, "rand_after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Sequencer that walks a rectangular pixel region row by row and emits one (x, y) coordinate per beat on a valid/ready stream. It sits in front of the rasterizer/fill datapath. Nested column and row counters supply addresses; a small FSM handles start, backpressure, abort and completion.

## Interface
- COORD_BITS, 10, width of coordinates, region size and origin fields
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin a scan; honoured only in IDLE
- abort  in  1  terminate current scan; honoured only in SCAN
- x0  in  COORD_BITS  region origin column, sampled on accepted start
- y0  in  COORD_BITS  region origin row, sampled on accepted start
- width  in  COORD_BITS  columns per row, sampled on accepted start
- height  in  COORD_BITS  number of rows, sampled on accepted start
- out_ready  in  1  downstream accepts the current beat
- out_valid  out  1  px/py/last hold a valid beat
- px  out  COORD_BITS  current column
- py  out  COORD_BITS  current row
- last  out  1  current beat is the final pixel of the region
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SCAN, DONE. Reset puts the FSM in IDLE and clears all outputs and internal counters to 0.
- IDLE to SCAN: start=1 with width!=0 and height!=0. x0, y0, width and height are latched; the column count xc and row count yc are cleared.
- IDLE to DONE: start=1 with width==0 or height==0. No beats are emitted.
- In SCAN:
  - out_valid=1.
  - px=(x0+xc) mod 2^COORD_BITS; py=(y0+yc) mod 2^COORD_BITS. Wrap-around is silent.
  - last=1 iff xc==width-1 and yc==height-1.
- Beat accepted (out_valid&out_ready):
  - If xc==width-1: xc goes to 0 and yc increments.
  - Otherwise xc increments.
  - If the accepted beat is the last beat, the FSM goes to DONE.
- Backpressure: while out_valid&!out_ready, px, py, last and the counters hold unchanged.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditional return to IDLE.
- abort=1 in SCAN: go to IDLE at the next edge. No done pulse. A beat accepted in the same cycle still counts as transferred. abort takes priority over the last-beat transition to DONE.
- start outside IDLE and abort outside SCAN are ignored.
- Latched parameters are immune to input changes mid-scan.
- Maximum region is (2^COORD_BITS-1)×(2^COORD_BITS-1). Counters are COORD_BITS wide and never overflow.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start latency: start sampled at edge k gives out_valid=1 from edge k+1.
- Throughput: one beat per cycle while out_ready=1. A W×H region takes W·H consecutive beats.
- The last beat accepted at edge n gives out_valid=0, done=1 and busy=1 after edge n, then done=0 and busy=0 after edge n+1.
- Back-to-back scans: the earliest next start is sampled in IDLE, i.e. at edge n+2 or later.
- Zero-size start at edge k gives done=1 after edge k and IDLE after edge k+1.
- Asynchronous reset mid-scan immediately forces out_valid, busy, done, last, px and py to 0 and the FSM to IDLE. No done pulse follows.

## Test plan
- Basic scan: x0=5, y0=7, width=3, height=2, out_ready=1.
  - Required: beats (5,7) (6,7) (7,7) (5,8) (6,8) (7,8) on consecutive cycles.
  - Required: last=1 only on (7,8); done pulses once the cycle after.
- Backpressure: same region with out_ready toggling 1,0,0,1,…
  - Required: each beat is held stable while ready=0; sequence identical to the basic scan; total beats 6.
- Zero size: width=0, height=4, start.
  - Required: out_valid never asserts; done=1 one cycle after start; busy high only that cycle.
- Abort: 4×4 region, abort asserted after 5 accepted beats.
  - Required: out_valid=0 next cycle; done never pulses; FSM returns to IDLE; a new start then scans correctly from origin.
- Wrap-around: COORD_BITS=10, x0=1022, width=4, height=1.
  - Required: px sequence 1022, 1023, 0, 1.
- Reset and ignored inputs:
  - Assert n_rst=0 asynchronously during beat 3 of a 3×3 scan. Required: outputs are 0 before the next clk edge and no done pulse follows.
  - Assert start during SCAN. Required: ignored.
